// File: rtl/imem_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         MIN_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM
    } framer_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, false-start rejection
// and stop-bit check. Produces one-cycle rx_valid or rx_ferr pulses.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_inter,
    input  logic       RESETn,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CPB   = (CLKS_PER_BIT < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : CLKS_PER_BIT;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);

    logic             meta_reg, sync_reg, prev_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;

    always_ff @(posedge clk_inter or negedge RESETn) begin
        if (!RESETn) begin
            meta_reg    <= 1'b1;
            sync_reg    <= 1'b1;
            prev_reg    <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            meta_reg    <= uart_rx;
            sync_reg    <= meta_reg;
            prev_reg    <= sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (prev_reg && !sync_reg) state_next = RX_START;
            end
            RX_START: begin
                // Line back high at mid-start-bit means a glitch, not a start bit.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {sync_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    valid_next = sync_reg;
                    ferr_next  = !sync_reg;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte  = shift_reg;
    assign rx_valid = valid_reg;
    assign rx_ferr  = ferr_reg;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed, checksummed program image from UART into instruction memory
// and holds the core in reset until a complete image has been accepted.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 10
) (
    input  logic              clk_inter,
    input  logic              RESETn,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_resetn,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_inter (clk_inter),
        .RESETn    (RESETn),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ferr   (rx_ferr)
    );

    framer_state_t     state_reg, state_next;
    logic [7:0]        len_lo_reg, len_lo_next;
    logic [15:0]       words_left_reg, words_left_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic [31:0]       asm_reg, asm_next;
    logic [7:0]        sum_reg, sum_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              we_reg, we_next;
    logic              core_rstn_reg, core_rstn_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              do_fail;
    logic [15:0]       len_word;

    assign len_word = {rx_byte, len_lo_reg};

    always_ff @(posedge clk_inter or negedge RESETn) begin
        if (!RESETn) begin
            state_reg      <= S_IDLE;
            len_lo_reg     <= '0;
            words_left_reg <= '0;
            byte_idx_reg   <= '0;
            asm_reg        <= '0;
            sum_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            core_rstn_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_lo_reg     <= len_lo_next;
            words_left_reg <= words_left_next;
            byte_idx_reg   <= byte_idx_next;
            asm_reg        <= asm_next;
            sum_reg        <= sum_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            we_reg         <= we_next;
            core_rstn_reg  <= core_rstn_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_lo_next     = len_lo_reg;
        words_left_next = words_left_reg;
        byte_idx_next   = byte_idx_reg;
        asm_next        = asm_reg;
        sum_next        = sum_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        we_next         = 1'b0;
        core_rstn_next  = core_rstn_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        do_fail         = 1'b0;

        // Advance only while more words follow, so the last address never wraps.
        if (we_reg && state_reg == S_DATA) addr_next = addr_reg + 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    core_rstn_next = 1'b0;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
                    busy_next      = 1'b1;
                    addr_next      = '0;
                    sum_next       = '0;
                    state_next     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_ferr) do_fail = 1'b1;
                else if (rx_valid) begin
                    len_lo_next = rx_byte;
                    state_next  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_ferr) do_fail = 1'b1;
                else if (rx_valid) begin
                    if ({1'b0, len_word} > MAX_WORDS) do_fail = 1'b1;
                    else if (len_word == 16'd0) state_next = S_CSUM;
                    else begin
                        words_left_next = len_word;
                        byte_idx_next   = '0;
                        state_next      = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_ferr) do_fail = 1'b1;
                else if (rx_valid) begin
                    sum_next                     = sum_reg + rx_byte;
                    asm_next[8*byte_idx_reg +: 8] = rx_byte;
                    byte_idx_next                = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        wdata_next      = asm_next;
                        we_next         = 1'b1;
                        words_left_next = words_left_reg - 16'd1;
                        if (words_left_reg == 16'd1) state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_ferr) do_fail = 1'b1;
                else if (rx_valid) begin
                    if (rx_byte == sum_reg) begin
                        done_next      = 1'b1;
                        core_rstn_next = 1'b1;
                        busy_next      = 1'b0;
                        state_next     = S_IDLE;
                    end else do_fail = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Already-written words stay in memory; the core simply stays held.
        if (do_fail) begin
            err_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
        end
    end

    assign imem_we     = we_reg;
    assign imem_addr   = addr_reg;
    assign imem_wdata  = wdata_reg;
    assign core_resetn = core_rstn_reg;
    assign load_busy   = busy_reg;
    assign load_done   = done_reg;
    assign load_err    = err_reg;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: good/bad loads, glitches, zero length,
// oversize, framing error, reload and mid-frame reset.
module tb_imem_uart_loader;

    localparam int CPB = 16;
    localparam int AW  = 10;

    typedef logic [7:0] byte_q_t [$];

    logic          clk_inter = 1'b0;
    logic          RESETn;
    logic          uart_rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_resetn, load_busy, load_done, load_err;

    int checks   = 0;
    int failures = 0;

    int          wr_cnt = 0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    logic        valid_seen       = 1'b0;
    logic        core_at_valid    = 1'b0;
    logic        core_after_valid = 1'b0;
    logic        done_after_valid = 1'b0;
    byte_q_t     frame;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk_inter   (clk_inter),
        .RESETn      (RESETn),
        .uart_rx     (uart_rx),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_resetn (core_resetn),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk_inter = ~clk_inter;

    // Log writes, and core_resetn/load_done on the rx_valid cycle and the one after.
    always @(negedge clk_inter) begin
        if (imem_we && wr_cnt < 8) begin
            wr_addr[wr_cnt] = 32'(imem_addr);
            wr_data[wr_cnt] = imem_wdata;
        end
        if (imem_we) wr_cnt++;
        if (valid_seen) begin
            core_after_valid = core_resetn;
            done_after_valid = load_done;
        end
        if (dut.rx_valid) core_at_valid = core_resetn;
        valid_seen = dut.rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk_inter);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk_inter);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk_inter);
        uart_rx = 1'b1;
    endtask

    task automatic send_q(input byte_q_t q);
        foreach (q[i]) send_bits(q[i], 1'b1);
        @(negedge clk_inter);
    endtask

    initial begin
        uart_rx = 1'b1;
        RESETn  = 1'b0;
        repeat (3) @(posedge clk_inter);
        @(negedge clk_inter);
        check("rst_core",  32'(core_resetn), 32'd0);
        check("rst_busy",  32'(load_busy),   32'd0);
        check("rst_done",  32'(load_done),   32'd0);
        check("rst_err",   32'(load_err),    32'd0);
        check("rst_we",    32'(imem_we),     32'd0);
        check("rst_addr",  32'(imem_addr),   32'd0);
        check("rst_wdata", imem_wdata,       32'd0);
        RESETn = 1'b1;
        repeat (5) @(posedge clk_inter);

        // Glitch bytes and a short low pulse must leave the loader idle.
        frame = '{8'h00, 8'hFF};
        send_q(frame);
        uart_rx = 1'b0;
        repeat (4) @(posedge clk_inter);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk_inter);
        @(negedge clk_inter);
        check("noise_wr",   32'(wr_cnt),    32'd0);
        check("noise_err",  32'(load_err),  32'd0);
        check("noise_busy", 32'(load_busy), 32'd0);

        // Zero-length image; checksum of no bytes is 0.
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(frame);
        check("zl_done", 32'(load_done),   32'd1);
        check("zl_core", 32'(core_resetn), 32'd1);
        check("zl_err",  32'(load_err),    32'd0);
        check("zl_wr",   32'(wr_cnt),      32'd0);

        // Reload: a new sync byte drops core_resetn the cycle after its rx_valid.
        frame = '{8'hA5};
        send_q(frame);
        check("reload_core_pre",  32'(core_at_valid),    32'd1);
        check("reload_core_post", 32'(core_after_valid), 32'd0);
        check("reload_busy",      32'(load_busy),        32'd1);
        check("reload_done_clr",  32'(load_done),        32'd0);

        // Two words; checksum 0x13+0x50+0x93+0x10 = 0x106 -> 0x06.
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h06};
        send_q(frame);
        check("good_wr_cnt",    32'(wr_cnt),           32'd2);
        check("good_addr0",     wr_addr[0],            32'd0);
        check("good_data0",     wr_data[0],            32'h0050_0013);
        check("good_addr1",     wr_addr[1],            32'd1);
        check("good_data1",     wr_data[1],            32'h0010_0093);
        check("good_core_pre",  32'(core_at_valid),    32'd0);
        check("good_core_post", 32'(core_after_valid), 32'd1);
        check("good_done_post", 32'(done_after_valid), 32'd1);
        check("good_err",       32'(load_err),         32'd0);
        check("good_busy",      32'(load_busy),        32'd0);

        // Same image, wrong checksum.
        wr_cnt = 0;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h47};
        send_q(frame);
        check("bad_err",  32'(load_err),    32'd1);
        check("bad_core", 32'(core_resetn), 32'd0);
        check("bad_done", 32'(load_done),   32'd0);
        check("bad_busy", 32'(load_busy),   32'd0);
        check("bad_wr",   32'(wr_cnt),      32'd2);

        // Oversize: N = 1025 words with a 10-bit address.
        wr_cnt = 0;
        frame = '{8'hA5};
        send_q(frame);
        check("ovs_err_clr", 32'(load_err),  32'd0);
        check("ovs_busy",    32'(load_busy), 32'd1);
        frame = '{8'h01, 8'h04};
        send_q(frame);
        check("ovs_err",  32'(load_err),    32'd1);
        check("ovs_busy_clr", 32'(load_busy), 32'd0);
        check("ovs_core", 32'(core_resetn), 32'd0);
        check("ovs_wr",   32'(wr_cnt),      32'd0);

        // Framing error on a data byte.
        frame = '{8'hA5, 8'h01, 8'h00};
        send_q(frame);
        check("ferr_busy_pre", 32'(load_busy), 32'd1);
        send_bits(8'h11, 1'b0);
        repeat (CPB) @(posedge clk_inter);
        @(negedge clk_inter);
        check("ferr_err",  32'(load_err),    32'd1);
        check("ferr_core", 32'(core_resetn), 32'd0);
        check("ferr_busy", 32'(load_busy),   32'd0);
        check("ferr_wr",   32'(wr_cnt),      32'd0);

        // Reset in the middle of the second word.
        frame = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_q(frame);
        check("mid_wr",   32'(wr_cnt),   32'd1);
        check("mid_data", wr_data[0],    32'hDDCC_BBAA);
        check("mid_addr", 32'(imem_addr), 32'd1);
        RESETn = 1'b0;
        #1;
        check("arst_flags", {27'd0, load_busy, core_resetn, load_done, load_err, imem_we}, 32'd0);
        check("arst_addr",  32'(imem_addr), 32'd0);
        check("arst_wdata", imem_wdata,     32'd0);
        @(posedge clk_inter);
        RESETn = 1'b1;
        wr_cnt = 0;
        repeat (4) @(posedge clk_inter);

        // Fresh load after reset; checksum 0x78+0x56+0x34+0x12 = 0x114 -> 0x14.
        frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_q(frame);
        check("post_wr",   32'(wr_cnt),      32'd1);
        check("post_addr", wr_addr[0],       32'd0);
        check("post_data", wr_data[0],       32'h1234_5678);
        check("post_done", 32'(load_done),   32'd1);
        check("post_core", 32'(core_resetn), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
